sap_control_unit: RTL

Microsequencer for the SAP-1.5 datapath. Sequences fetch/decode/execute over the bus-attached registers (PC, MAR, IR, A, B, OUT, flags) by driving their load and output-enable strobes each T-state. Sits beside the IR: it consumes the latched opcode and ALU flags and produces one control word per clock. The block owns no data path; all data registers live outside it.

---
 rtl/sap_pkg.sv | 56 +++++
 rtl/sap_control_unit_if.sv | 28 ++
 rtl/sap_control_decoder.sv | 98 +++++++++
 rtl/sap_control_unit.sv | 65 ++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared opcode, state and control-word definitions for the SAP-1.5 microsequencer.
// Optional conditional-jump support is selected by SAP_COND_JUMP_EN.
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // HALT sits at 7 so the state register can be exported directly as the step number
  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic pc_oe;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_oe;
    logic ram_we;
    logic ir_load;
    logic ir_oe;
    logic a_load;
    logic a_oe;
    logic b_load;
    logic alu_oe;
    logic alu_sub;
    logic out_load;
    logic flags_load;
  } ctrl_word_t;

  localparam int CW_W = $bits(ctrl_word_t);

  // Number of execute steps (T2 onward) an opcode occupies
  function automatic logic [1:0] exec_steps(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: exec_steps = 2'd2;
      OP_ADD, OP_SUB: exec_steps = 2'd3;
      default:        exec_steps = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/sap_control_unit_if.sv
// Opcode/flag inputs and control-strobe outputs between the microsequencer and the datapath.
interface sap_control_unit_if;
  logic [3:0] opcode;
  logic       flag_carry;
  logic       flag_zero;
  logic       pc_oe, pc_inc, pc_load;
  logic       mar_load;
  logic       ram_oe, ram_we;
  logic       ir_load, ir_oe;
  logic       a_load, a_oe, b_load;
  logic       alu_oe, alu_sub;
  logic       out_load;
  logic       flags_load;
  logic       halt;
  logic [2:0] step;

  modport master (
    input  opcode, flag_carry, flag_zero,
    output pc_oe, pc_inc, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe,
           a_load, a_oe, b_load, alu_oe, alu_sub, out_load, flags_load, halt, step
  );

  modport slave (
    output opcode, flag_carry, flag_zero,
    input  pc_oe, pc_inc, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe,
           a_load, a_oe, b_load, alu_oe, alu_sub, out_load, flags_load, halt, step
  );
endinterface

// File: rtl/sap_control_decoder.sv
// Combinational control-word decode from T-state, opcode and flags.
// SAP_COND_JUMP_EN enables JC/JZ and the flags_load strobe of ADD/SUB.
module sap_control_decoder
  import sap_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       flag_carry,
  input  logic       flag_zero,
  output ctrl_word_t cw,
  output logic       last
);

`ifndef SAP_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = flag_carry ^ flag_zero;
`endif

  always_comb begin
    cw   = '0;
    last = 1'b0;
    case (state)
      T0: begin
        cw.pc_oe    = 1'b1;
        cw.mar_load = 1'b1;
      end
      T1: begin
        cw.ram_oe  = 1'b1;
        cw.ir_load = 1'b1;
        cw.pc_inc  = 1'b1;
      end
      T2: begin
        last = (exec_steps(opcode) == 2'd1);
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw.ir_oe    = 1'b1;
            cw.mar_load = 1'b1;
          end
          OP_LDI: begin
            cw.ir_oe  = 1'b1;
            cw.a_load = 1'b1;
          end
          OP_JMP: begin
            cw.ir_oe   = 1'b1;
            cw.pc_load = 1'b1;
          end
`ifdef SAP_COND_JUMP_EN
          // Flags are only consulted here; the jump is a plain JMP when taken
          OP_JC: begin
            cw.ir_oe   = flag_carry;
            cw.pc_load = flag_carry;
          end
          OP_JZ: begin
            cw.ir_oe   = flag_zero;
            cw.pc_load = flag_zero;
          end
`endif
          OP_OUT: begin
            cw.a_oe     = 1'b1;
            cw.out_load = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        last = (exec_steps(opcode) == 2'd2);
        case (opcode)
          OP_LDA: begin
            cw.ram_oe = 1'b1;
            cw.a_load = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw.ram_oe = 1'b1;
            cw.b_load = 1'b1;
          end
          OP_STA: begin
            cw.a_oe   = 1'b1;
            cw.ram_we = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        last = 1'b1;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw.alu_oe  = 1'b1;
          cw.a_load  = 1'b1;
          cw.alu_sub = (opcode == OP_SUB);
`ifdef SAP_COND_JUMP_EN
          cw.flags_load = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sap_control_unit.sv
// SAP-1.5 microsequencer top: T-state register, next-state logic and reset gating of strobes.
// Build option SAP_COND_JUMP_EN is honoured by the decoder.
module sap_control_unit
  import sap_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  sap_control_unit_if.master bus
);

  state_t     state, state_nxt;
  ctrl_word_t cw, cw_out;
  logic       last;

  sap_control_decoder u_dec (
    .state      (state),
    .opcode     (bus.opcode),
    .flag_carry (bus.flag_carry),
    .flag_zero  (bus.flag_zero),
    .cw         (cw),
    .last       (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= T0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      T0: state_nxt = T1;
      T1: state_nxt = T2;
      T2, T3, T4: begin
        if (state == T2 && bus.opcode == OP_HLT) state_nxt = HALT;
        else if (last)                           state_nxt = T0;
        else                                     state_nxt = state_t'(state + 3'd1);
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = T0;
    endcase
  end

  // Strobes are forced low for the whole time reset is high, not just after the edge
  assign cw_out = reset ? '0 : cw;

  assign bus.pc_oe      = cw_out.pc_oe;
  assign bus.pc_inc     = cw_out.pc_inc;
  assign bus.pc_load    = cw_out.pc_load;
  assign bus.mar_load   = cw_out.mar_load;
  assign bus.ram_oe     = cw_out.ram_oe;
  assign bus.ram_we     = cw_out.ram_we;
  assign bus.ir_load    = cw_out.ir_load;
  assign bus.ir_oe      = cw_out.ir_oe;
  assign bus.a_load     = cw_out.a_load;
  assign bus.a_oe       = cw_out.a_oe;
  assign bus.b_load     = cw_out.b_load;
  assign bus.alu_oe     = cw_out.alu_oe;
  assign bus.alu_sub    = cw_out.alu_sub;
  assign bus.out_load   = cw_out.out_load;
  assign bus.flags_load = cw_out.flags_load;
  assign bus.halt       = !reset && (state == HALT);
  assign bus.step       = state;

endmodule
